// File: rtl/tagged_register_file.sv
// ---------------------------------------------------------------------------
// tagged_register_file
//
// Architectural register file with per-register busy/owner (rename tag)
// tracking. Dispatch ports mark destinations busy and record the producing
// tag; retirement ports write values and release busy only while the
// retiring tag still owns the register. Read ports are registered (1 cycle).
//
// Per-cycle update order: retire, then dispatch, then flush.
//
// Optional feature macro: TAGFILE_BYPASS_EN
//   defined   : read ports capture the post-update state of the same edge
//   undefined : read ports capture the pre-update state
//
// Ports (port i occupies slice [i*W +: W]):
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   rd_addr    in   NUM_READ*AW        read register index per port
//   rd_value   out  NUM_READ*DATA_W    registered value
//   rd_busy    out  NUM_READ           registered busy bit
//   rd_owner   out  NUM_READ*TAG_W     registered owner tag
//   disp_en    in   NUM_DISPATCH       allocate request valid
//   disp_reg   in   NUM_DISPATCH*AW    destination register
//   disp_tag   in   NUM_DISPATCH*TAG_W producing tag
//   ret_en     in   NUM_RETIRE         retirement write valid
//   ret_reg    in   NUM_RETIRE*AW      target register
//   ret_data   in   NUM_RETIRE*DATA_W  write data
//   ret_tag    in   NUM_RETIRE*TAG_W   retiring instruction's tag
//   flush      in   clear all busy bits, drop same-cycle dispatches
//   busy_count out  clog2(NUM_REGS+1)  registered count of busy registers
// ---------------------------------------------------------------------------
module tagged_register_file #(
  parameter int NUM_REGS     = 16,
  parameter int DATA_W       = 16,
  parameter int TAG_W        = 4,
  parameter int NUM_READ     = 8,
  parameter int NUM_DISPATCH = 4,
  parameter int NUM_RETIRE   = 4,
  localparam int AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CW          = $clog2(NUM_REGS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_READ*AW-1:0]          rd_addr,
  output logic [NUM_READ*DATA_W-1:0]      rd_value,
  output logic [NUM_READ-1:0]             rd_busy,
  output logic [NUM_READ*TAG_W-1:0]       rd_owner,
  input  logic [NUM_DISPATCH-1:0]         disp_en,
  input  logic [NUM_DISPATCH*AW-1:0]      disp_reg,
  input  logic [NUM_DISPATCH*TAG_W-1:0]   disp_tag,
  input  logic [NUM_RETIRE-1:0]           ret_en,
  input  logic [NUM_RETIRE*AW-1:0]        ret_reg,
  input  logic [NUM_RETIRE*DATA_W-1:0]    ret_data,
  input  logic [NUM_RETIRE*TAG_W-1:0]     ret_tag,
  input  logic                            flush,
  output logic [CW-1:0]                   busy_count
);

  localparam logic [AW:0] LIM = (AW+1)'(NUM_REGS);

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < LIM);
  endfunction

  // Architectural state
  logic [DATA_W-1:0]   r_val  [NUM_REGS];
  logic [TAG_W-1:0]    r_own  [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  // Post-update state for this edge
  logic [DATA_W-1:0]   w_val_nxt [NUM_REGS];
  logic [TAG_W-1:0]    w_own_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] w_clr;
  logic [CW-1:0]       w_count_nxt;

  // Read source (pre- or post-update depending on build)
  logic [DATA_W-1:0]   w_src_val [NUM_REGS];
  logic [TAG_W-1:0]    w_src_own [NUM_REGS];
  logic [NUM_REGS-1:0] w_src_busy;

  // Registered read outputs
  logic [NUM_READ*DATA_W-1:0] r_rd_value;
  logic [NUM_READ-1:0]        r_rd_busy;
  logic [NUM_READ*TAG_W-1:0]  r_rd_owner;
  logic [CW-1:0]              r_busy_count;

  always_comb begin
    w_val_nxt  = r_val;
    w_own_nxt  = r_own;
    w_busy_nxt = r_busy;
    w_clr      = '0;

    // Retire: ascending loop lets the highest port win the value. The busy
    // release is judged against pre-edge owner/busy, so any matching port
    // qualifies regardless of order.
    for (int unsigned i = 0; i < NUM_RETIRE; i++) begin
      if (ret_en[i] && in_range(ret_reg[i*AW +: AW])) begin
        w_val_nxt[ret_reg[i*AW +: AW]] = ret_data[i*DATA_W +: DATA_W];
        if (r_busy[ret_reg[i*AW +: AW]] &&
            (r_own[ret_reg[i*AW +: AW]] == ret_tag[i*TAG_W +: TAG_W]))
          w_clr[ret_reg[i*AW +: AW]] = 1'b1;
      end
    end
    w_busy_nxt = w_busy_nxt & ~w_clr;

    // Dispatch applied after the retire clear so it overrides it; youngest
    // (highest) port wins. Flush drops dispatches and clears everything.
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      for (int unsigned j = 0; j < NUM_DISPATCH; j++) begin
        if (disp_en[j] && in_range(disp_reg[j*AW +: AW])) begin
          w_busy_nxt[disp_reg[j*AW +: AW]] = 1'b1;
          w_own_nxt[disp_reg[j*AW +: AW]]  = disp_tag[j*TAG_W +: TAG_W];
        end
      end
    end

    w_count_nxt = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++)
      w_count_nxt = w_count_nxt + {{(CW-1){1'b0}}, w_busy_nxt[k]};
  end

  always_comb begin
`ifdef TAGFILE_BYPASS_EN
    w_src_val  = w_val_nxt;
    w_src_own  = w_own_nxt;
    w_src_busy = w_busy_nxt;
`else
    w_src_val  = r_val;
    w_src_own  = r_own;
    w_src_busy = r_busy;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        r_val[k] <= '0;
        r_own[k] <= '0;
      end
      r_busy       <= '0;
      r_busy_count <= '0;
      r_rd_value   <= '0;
      r_rd_busy    <= '0;
      r_rd_owner   <= '0;
    end else begin
      r_val        <= w_val_nxt;
      r_own        <= w_own_nxt;
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_count_nxt;
      for (int unsigned p = 0; p < NUM_READ; p++) begin
        if (in_range(rd_addr[p*AW +: AW])) begin
          r_rd_value[p*DATA_W +: DATA_W] <= w_src_val[rd_addr[p*AW +: AW]];
          r_rd_owner[p*TAG_W +: TAG_W]   <= w_src_own[rd_addr[p*AW +: AW]];
          r_rd_busy[p]                   <= w_src_busy[rd_addr[p*AW +: AW]];
        end else begin
          r_rd_value[p*DATA_W +: DATA_W] <= '0;
          r_rd_owner[p*TAG_W +: TAG_W]   <= '0;
          r_rd_busy[p]                   <= 1'b0;
        end
      end
    end
  end

  assign rd_value   = r_rd_value;
  assign rd_busy    = r_rd_busy;
  assign rd_owner   = r_rd_owner;
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_tagged_register_file.sv
module tb_tagged_register_file;

  // Non-power-of-two register count so indices NR..15 exercise the
  // out-of-range path on every port.
  localparam int NR  = 12;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int TW  = 4;
  localparam int NRD = 8;
  localparam int ND  = 4;
  localparam int NRT = 4;
  localparam int CW  = 4;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_value;
  logic [NRD-1:0]    rd_busy;
  logic [NRD*TW-1:0] rd_owner;
  logic [ND-1:0]     disp_en;
  logic [ND*AW-1:0]  disp_reg;
  logic [ND*TW-1:0]  disp_tag;
  logic [NRT-1:0]    ret_en;
  logic [NRT*AW-1:0] ret_reg;
  logic [NRT*DW-1:0] ret_data;
  logic [NRT*TW-1:0] ret_tag;
  logic              flush;
  logic [CW-1:0]     busy_count;

  tagged_register_file #(
    .NUM_REGS(NR), .DATA_W(DW), .TAG_W(TW),
    .NUM_READ(NRD), .NUM_DISPATCH(ND), .NUM_RETIRE(NRT)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_value(rd_value), .rd_busy(rd_busy), .rd_owner(rd_owner),
    .disp_en(disp_en), .disp_reg(disp_reg), .disp_tag(disp_tag),
    .ret_en(ret_en), .ret_reg(ret_reg), .ret_data(ret_data), .ret_tag(ret_tag),
    .flush(flush), .busy_count(busy_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what each architectural register holds
  logic [DW-1:0] m_val  [NR];
  logic          m_busy [NR];
  logic [TW-1:0] m_own  [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rd_addr = '0; disp_en = '0; disp_reg = '0; disp_tag = '0;
    ret_en = '0; ret_reg = '0; ret_data = '0; ret_tag = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input int r);
    rd_addr[p*AW +: AW] = AW'(r);
  endtask

  task automatic set_disp(input int p, input int r, input int t);
    disp_en[p] = 1'b1; disp_reg[p*AW +: AW] = AW'(r); disp_tag[p*TW +: TW] = TW'(t);
  endtask

  task automatic set_ret(input int p, input int r, input int d, input int t);
    ret_en[p] = 1'b1; ret_reg[p*AW +: AW] = AW'(r);
    ret_data[p*DW +: DW] = DW'(d); ret_tag[p*TW +: TW] = TW'(t);
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_val[r] = '0; m_busy[r] = 1'b0; m_own[r] = '0;
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " rd_value"}, rd_value[31:0], 32'h0);
    chk({nm, " rd_value_hi"}, 32'(rd_value[NRD*DW-1:32] != '0), 32'h0);
    chk({nm, " rd_busy"}, 32'(rd_busy), 32'h0);
    chk({nm, " rd_owner"}, rd_owner[31:0], 32'h0);
    chk({nm, " busy_count"}, 32'(busy_count), 32'h0);
  endtask

  // Apply the currently driven inputs for one clock edge, predict every
  // output from the architectural rules, then compare after the edge.
  task automatic step();
    logic [DW-1:0] nv [NR];
    logic          nb [NR];
    logic [TW-1:0] no [NR];
    logic          rel [NR];
    logic [DW-1:0] ev [NRD];
    logic          eb [NRD];
    logic [TW-1:0] eo [NRD];
    int cnt, a;
    nv = m_val; nb = m_busy; no = m_own;
    for (int r = 0; r < NR; r++) rel[r] = 1'b0;
    for (int i = 0; i < NRT; i++) begin
      a = int'(ret_reg[i*AW +: AW]);
      if (ret_en[i] && a < NR) begin
        nv[a] = ret_data[i*DW +: DW];
        if (m_busy[a] && m_own[a] == ret_tag[i*TW +: TW]) rel[a] = 1'b1;
      end
    end
    for (int r = 0; r < NR; r++) if (rel[r]) nb[r] = 1'b0;
    if (flush) begin
      for (int r = 0; r < NR; r++) nb[r] = 1'b0;
    end else begin
      for (int j = 0; j < ND; j++) begin
        a = int'(disp_reg[j*AW +: AW]);
        if (disp_en[j] && a < NR) begin
          nb[a] = 1'b1; no[a] = disp_tag[j*TW +: TW];
        end
      end
    end
    cnt = 0;
    for (int r = 0; r < NR; r++) cnt += int'(nb[r]);
    for (int p = 0; p < NRD; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      if (a >= NR) begin
        ev[p] = '0; eb[p] = 1'b0; eo[p] = '0;
      end else begin
`ifdef TAGFILE_BYPASS_EN
        ev[p] = nv[a]; eb[p] = nb[a]; eo[p] = no[a];
`else
        ev[p] = m_val[a]; eb[p] = m_busy[a]; eo[p] = m_own[a];
`endif
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rd_value[%0d]", p), 32'(rd_value[p*DW +: DW]), 32'(ev[p]));
      chk($sformatf("rd_busy[%0d]", p),  32'(rd_busy[p]),           32'(eb[p]));
      chk($sformatf("rd_owner[%0d]", p), 32'(rd_owner[p*TW +: TW]), 32'(eo[p]));
    end
    chk("busy_count", 32'(busy_count), 32'(cnt));
    m_val = nv; m_busy = nb; m_own = no;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_clear();
    #12 rst = 1'b0;

    // Reset state: read r0..r7
    for (int p = 0; p < 8; p++) set_rd(p, p);
    step();
    check_all_zero("reset_read");

    // Dispatch r3 tag 5, then read
    clear_inputs(); set_disp(0, 3, 5); step();
    clear_inputs(); set_rd(0, 3); step();
    chk("disp_busy", 32'(rd_busy[0]), 32'd1);
    chk("disp_owner", 32'(rd_owner[3:0]), 32'd5);
    chk("disp_count", 32'(busy_count), 32'd1);

    // Retire r3 tag 5 with 0xBEEF
    clear_inputs(); set_ret(0, 3, 16'hBEEF, 5); step();
    clear_inputs(); set_rd(0, 3); step();
    chk("ret_value", 32'(rd_value[15:0]), 32'hBEEF);
    chk("ret_busy", 32'(rd_busy[0]), 32'd0);

    // Stale retire must not release a re-dispatched register
    clear_inputs(); set_disp(0, 3, 5); step();
    clear_inputs(); set_disp(1, 3, 9); step();
    clear_inputs(); set_ret(2, 3, 16'h1234, 5); step();
    clear_inputs(); set_rd(0, 3); step();
    chk("stale_value", 32'(rd_value[15:0]), 32'h1234);
    chk("stale_busy", 32'(rd_busy[0]), 32'd1);
    chk("stale_owner", 32'(rd_owner[3:0]), 32'd9);

    // Same-cycle retire+dispatch on r2; ports 0 and 3 both dispatch r4
    clear_inputs(); set_disp(0, 2, 1); step();
    clear_inputs();
    set_ret(0, 2, 16'h5555, 1); set_disp(1, 2, 7);
    set_disp(0, 4, 2); set_disp(3, 4, 6);
    step();
    clear_inputs(); set_rd(0, 2); set_rd(1, 4); step();
    chk("rd2_value", 32'(rd_value[15:0]), 32'h5555);
    chk("rd2_busy", 32'(rd_busy[0]), 32'd1);
    chk("rd2_owner", 32'(rd_owner[3:0]), 32'd7);
    chk("r4_owner", 32'(rd_owner[7:4]), 32'd6);

    // Six busy (r2,r3,r4 + r0,r1,r5), then flush with a dispatch to r1
    clear_inputs(); set_disp(0, 0, 1); set_disp(1, 1, 2); set_disp(2, 5, 3); step();
    chk("six_busy", 32'(busy_count), 32'd6);
    clear_inputs(); flush = 1'b1; set_disp(0, 1, 3); step();
    chk("flush_count", 32'(busy_count), 32'd0);
    clear_inputs(); set_rd(0, 1); step();
    chk("flush_r1_busy", 32'(rd_busy[0]), 32'd0);

    // Same-cycle retire and read of r6
    clear_inputs(); set_ret(0, 6, 16'h0011, 0); step();
    clear_inputs(); set_ret(1, 6, 16'h00AA, 0); set_rd(0, 6); step();
`ifdef TAGFILE_BYPASS_EN
    chk("r6_sameedge", 32'(rd_value[15:0]), 32'h00AA);
`else
    chk("r6_sameedge", 32'(rd_value[15:0]), 32'h0011);
`endif
    clear_inputs(); set_rd(0, 6); step();
    chk("r6_next", 32'(rd_value[15:0]), 32'h00AA);

    // Out-of-range index: dispatch ignored, read returns zeros
    clear_inputs(); set_disp(0, 13, 4); set_ret(0, 14, 16'hFFFF, 4); set_rd(0, 13); step();
    chk("oor_count", 32'(busy_count), 32'd0);
    chk("oor_read", 32'(rd_value[15:0]), 32'h0);

    // Mid-sequence asynchronous reset
    clear_inputs(); set_disp(0, 7, 3); set_disp(1, 8, 4); set_rd(0, 6); step();
    clear_inputs(); flush = 1'b1; set_rd(0, 7);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1;
    check_all_zero("held_reset");
    #2 rst = 1'b0;
    model_clear();
    clear_inputs(); for (int p = 0; p < 8; p++) set_rd(p, p); step();
    check_all_zero("post_reset_read");

    // Randomized traffic
    for (int it = 0; it < 2000; it++) begin
      int span;
      clear_inputs();
      span = ($urandom_range(3) == 0) ? 3 : 15;
      for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(span));
      for (int j = 0; j < ND; j++)
        if ($urandom_range(1) == 1) set_disp(j, $urandom_range(span), $urandom_range(15));
      for (int i = 0; i < NRT; i++)
        if ($urandom_range(1) == 1) set_ret(i, $urandom_range(span), $urandom_range(16'hFFFF), $urandom_range(3));
      flush = ($urandom_range(15) == 0);
      step();
      if (it == 1000) begin
        #2 rst = 1'b1;
        #1 check_all_zero("rand_reset");
        #2 rst = 1'b0;
        model_clear();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
